// File: rtl/div_pkg.sv
// Shared definitions for the iterative divider: FSM state encodings,
// handshake levels and the EX-stage opcodes that select a division.
package div_pkg;

  // Divider sequencing states
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  // Result valid levels
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Start request levels
  localparam logic DivStart = 1'b1;
  localparam logic DivStop  = 1'b0;

  // ALU opcodes routed to the divider by EX
  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

endpackage

// File: rtl/div_if.sv
// Request/result bundle between the EX stage (master) and the divider (slave).
interface div_if #(
  parameter int WIDTH = 32
);

  logic               signed_div_i;
  logic [WIDTH-1:0]   opdata1_i;
  logic [WIDTH-1:0]   opdata2_i;
  logic               start_i;
  logic               annul_i;
  logic [2*WIDTH-1:0] result_o;
  logic               ready_o;

  modport master (
    output signed_div_i,
    output opdata1_i,
    output opdata2_i,
    output start_i,
    output annul_i,
    input  result_o,
    input  ready_o
  );

  modport slave (
    input  signed_div_i,
    input  opdata1_i,
    input  opdata2_i,
    input  start_i,
    input  annul_i,
    output result_o,
    output ready_o
  );

endinterface

// File: rtl/div.sv
// Iterative radix-2 restoring divider, one quotient bit per clock.
//
// state     | meaning
// ----------+---------------------------------------------------------
// DivFree   | idle, waiting for start; outputs held at zero
// DivByZero | divisor was zero, result forced to zero
// DivOn     | WIDTH restoring steps, then sign fix-up
// DivEnd    | result valid while start stays high
module div
  import div_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic  clk,
  input logic  rst,
  div_if.slave bus
);

  localparam int             CW      = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]  CNT_END = CW'(WIDTH);

  div_state_e         r_state;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_rem;
  logic [WIDTH-1:0]   r_quo;
  logic [WIDTH-1:0]   r_dvs;
  logic               r_neg_q;
  logic               r_neg_r;
  logic               r_ready;
  logic [2*WIDTH-1:0] r_result;

  logic [WIDTH-1:0]   w_op1_abs;
  logic [WIDTH-1:0]   w_op2_abs;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_sub;
  logic               w_ge;
  logic [WIDTH-1:0]   w_quo_fix;
  logic [WIDTH-1:0]   w_rem_fix;

  // Operand magnitudes; only signed requests fold negatives to positive.
  always_comb begin
    w_op1_abs = bus.opdata1_i;
    w_op2_abs = bus.opdata2_i;
    if (bus.signed_div_i && bus.opdata1_i[WIDTH-1]) w_op1_abs = -bus.opdata1_i;
    if (bus.signed_div_i && bus.opdata2_i[WIDTH-1]) w_op2_abs = -bus.opdata2_i;
  end

  // One restoring step. The remainder is always below the divisor, so the
  // shifted value is below twice the divisor and the top bit of a WIDTH+1
  // bit difference is a clean borrow flag.
  always_comb begin
    w_shift = {r_rem, r_quo[WIDTH-1]};
    w_sub   = w_shift - {1'b0, r_dvs};
    w_ge    = ~w_sub[WIDTH];
  end

  // Sign restoration: quotient negative when signs differ, remainder
  // follows the dividend.
  always_comb begin
    w_quo_fix = r_neg_q ? -r_quo : r_quo;
    w_rem_fix = r_neg_r ? -r_rem : r_rem;
  end

  // Sequencing FSM with registered datapath and outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= DivFree;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_dvs    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_ready  <= DivResultNotReady;
      r_result <= '0;
    end else begin
      case (r_state)
        DivFree: begin
          r_ready  <= DivResultNotReady;
          r_result <= '0;
          if (bus.start_i == DivStart && !bus.annul_i) begin
            if (bus.opdata2_i == '0) begin
              r_state <= DivByZero;
            end else begin
              r_state <= DivOn;
              r_cnt   <= '0;
              r_rem   <= '0;
              r_quo   <= w_op1_abs;
              r_dvs   <= w_op2_abs;
              r_neg_q <= bus.signed_div_i &
                         (bus.opdata1_i[WIDTH-1] ^ bus.opdata2_i[WIDTH-1]);
              r_neg_r <= bus.signed_div_i & bus.opdata1_i[WIDTH-1];
            end
          end
        end

        DivByZero: begin
          r_rem   <= '0;
          r_quo   <= '0;
          r_state <= DivEnd;
        end

        DivOn: begin
          if (bus.annul_i) begin
            r_state <= DivFree;
          end else if (r_cnt != CNT_END) begin
            r_rem <= w_ge ? w_sub[WIDTH-1:0] : w_shift[WIDTH-1:0];
            r_quo <= {r_quo[WIDTH-2:0], w_ge};
            r_cnt <= r_cnt + CW'(1);
          end else begin
            r_quo   <= w_quo_fix;
            r_rem   <= w_rem_fix;
            r_cnt   <= '0;
            r_state <= DivEnd;
          end
        end

        DivEnd: begin
          if (bus.start_i == DivStart) begin
            r_ready  <= DivResultReady;
            r_result <= {r_rem, r_quo};
          end else begin
            r_state  <= DivFree;
            r_ready  <= DivResultNotReady;
            r_result <= '0;
          end
        end

        default: r_state <= DivFree;
      endcase
    end
  end

  assign bus.ready_o  = r_ready;
  assign bus.result_o = r_result;

endmodule

// File: tb/tb_div.sv
// Directed bench for the iterative divider: latency, signed/unsigned
// results, divide-by-zero, annul and asynchronous reset.
module tb_div;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  div_if #(.WIDTH(32)) bus ();

  div #(.WIDTH(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // 100 MHz clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Full transaction: start, count edges to ready, check result, hold, release.
  task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                         input logic [31:0] b, input int exp_lat, input logic [63:0] exp_res);
    int n;
    @(negedge clk);
    bus.signed_div_i = sgn;
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.start_i      = 1'b1;
    @(posedge clk);
    #1;
    bus.opdata1_i = ~a;
    bus.opdata2_i = b ^ 32'h5A5A_0F0F;
    n = 0;
    while (n < 100) begin
      @(posedge clk);
      n++;
      #1;
      if (bus.ready_o) break;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_res"}, bus.result_o, exp_res);
    @(posedge clk);
    #1;
    chk({tag, "_hold"}, {bus.ready_o, bus.result_o[62:0]}, {1'b1, exp_res[62:0]});
    @(negedge clk);
    bus.start_i = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_drop"}, {63'd0, bus.ready_o} | bus.result_o, 64'd0);
  endtask

  initial begin
    int hits;
    n_total          = 0;
    n_bad            = 0;
    rst              = 1'b0;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = '0;
    bus.opdata2_i    = '0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_result", bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    run_div("u100_7",  1'b0, 32'd100,       32'd7,         34, {32'h0000_0002, 32'h0000_000E});
    run_div("s-7_2",   1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 34, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    run_div("s7_-2",   1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 34, {32'h0000_0001, 32'hFFFF_FFFD});
    run_div("s-100_-7",1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 34, {32'hFFFF_FFFE, 32'h0000_000E});
    run_div("uffff_16",1'b0, 32'hFFFF_FFFF, 32'h0000_0010, 34, {32'h0000_000F, 32'h0FFF_FFFF});
    run_div("s_ovf",   1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h0000_0000, 32'h8000_0000});
    run_div("u_ovf",   1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 34, {32'h8000_0000, 32'h0000_0000});
    run_div("u_zero",  1'b0, 32'd5,         32'd0,          2, 64'd0);
    run_div("s_zero",  1'b1, 32'hFFFF_FFF0, 32'd0,          2, 64'd0);

    // Annul ten cycles into ON; ready must never rise afterwards.
    @(negedge clk);
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd100;
    bus.opdata2_i    = 32'd7;
    bus.start_i      = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.annul_i = 1'b0;
    bus.start_i = 1'b0;
    hits = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.ready_o) hits++;
    end
    chk("annul_no_ready", 64'(hits), 64'd0);
    run_div("u9_3", 1'b0, 32'd9, 32'd3, 34, {32'd0, 32'd3});

    // Asynchronous reset in the middle of ON.
    @(negedge clk);
    bus.opdata1_i = 32'd1000;
    bus.opdata2_i = 32'd3;
    bus.start_i   = 1'b1;
    @(posedge clk);
    repeat (10) @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_on", {63'd0, bus.ready_o} | bus.result_o, 64'd0);
    @(negedge clk);
    rst = 1'b1;

    // Asynchronous reset while a valid result is being held.
    hits = 0;
    while (hits < 100 && !bus.ready_o) begin
      @(posedge clk);
      #1;
      hits++;
    end
    chk("pre_rst_end_ready", 64'(bus.ready_o), 64'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst_end_ready", 64'(bus.ready_o), 64'd0);
    chk("rst_end_result", bus.result_o, 64'd0);
    @(negedge clk);
    bus.start_i = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_idle", {63'd0, bus.ready_o} | bus.result_o, 64'd0);

    run_div("post_rst", 1'b0, 32'd1000, 32'd3, 34, {32'd1, 32'd333});

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/div.md
Name: div

Overview:
- Iterative 32-cycle radix-2 restoring divider with its own sequencing FSM.
- Serves the EX stage for DIV/DIVU. EX raises start_i and holds stallreq high until ready_o is high, then writes result_o to HI/LO.
- annul_i lets the pipeline abort an in-flight division.

Parameters:
WIDTH, 32, operand width; the iteration count equals WIDTH and the counter is clog2(WIDTH)+1 bits.

Ports:
clk  in  1  rising-edge clock
rst  in  1  asynchronous reset, active-low
signed_div_i  in  1  1 = signed (DIV), 0 = unsigned (DIVU)
opdata1_i  in  WIDTH  dividend
opdata2_i  in  WIDTH  divisor
start_i  in  1  request/hold; must stay high until ready_o is seen
annul_i  in  1  abort the current division
result_o  out  2*WIDTH  {remainder, quotient}
ready_o  out  1  result valid

Behaviour:
- Reset (rst low, asynchronous):
  - state = FREE, ready_o = 0, result_o = 0, counter = 0, internal registers = 0.
  - Reset mid-operation drops the division silently.
- States: FREE, BYZERO, ON, END. All state and output updates are registered.
- FREE:
  - On an edge E0 with start_i=1 and annul_i=0:
    - divisor == 0 → BYZERO.
    - otherwise → ON.
  - In the ON case, latch operands at E0. When signed_div_i=1, replace each negative operand by its two's-complement magnitude.
  - Also at E0: clear the partial remainder, load the dividend magnitude, counter = 0.
  - start_i low, or start_i together with annul_i → stay FREE.
- ON:
  - annul_i=1 → FREE at the next edge; ready_o stays 0 and result_o is not updated.
  - Otherwise, while counter < WIDTH, each edge performs one restoring step:
    - shift {partial remainder, dividend} left by 1;
    - if the shifted remainder ≥ divisor magnitude, subtract it and set the new quotient LSB to 1, else set it to 0;
    - counter += 1.
  - When counter == WIDTH, the next edge does the sign fix-up and goes to END.
- Sign fix-up (signed_div_i=1 only):
  - Negate the quotient if the original operand sign bits differ.
  - Negate the remainder if the original dividend was negative (remainder takes the dividend's sign).
  - 0x80000000 / 0xFFFFFFFF gives quotient 0x80000000, remainder 0, with no trap.
  - Unsigned results are passed through unchanged.
- BYZERO: next edge → END with result_o = 0. annul_i is ignored here.
- END:
  - ready_o = 1 and result_o holds the final value.
  - start_i=1 → stay in END, output stable.
  - start_i=0 → FREE at the next edge, with ready_o = 0 and result_o = 0 after that edge.
  - annul_i is ignored in END.
- Latency:
  - Nonzero divisor: ready_o is first high after edge E0+34 (1 load, 32 steps, 1 fix-up).
  - Zero divisor: ready_o is first high after edge E0+2.
- Operand inputs may change after E0 without affecting the in-flight result.
- A new start is accepted only from FREE. Back-to-back divisions need one FREE cycle between them.

Decomposition:
- Shared defines file gets:
  - state encodings DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11;
  - DivResultReady/DivResultNotReady;
  - DivStart/DivStop;
  - EXE_DIV_OP/EXE_DIVU_OP opcodes, if not already present.
- No sub-module. The step logic is one WIDTH+1-bit subtract, inline.
- EX-side stall/start glue lives in ex, not here.

Test Plan:
- Unsigned 100 / 7, start held until ready → ready_o first high after edge E0+34; result_o = {32'h00000002, 32'h0000000E}. Drop start → ready_o = 0, result_o = 0 one edge later.
- Signed -7 / 2 (0xFFFFFFF9, 0x00000002) → result_o = {32'hFFFFFFFF, 32'hFFFFFFFD}. Signed 7 / -2 → {32'h00000001, 32'hFFFFFFFD}.
- Divide by zero (any signedness) → ready_o high after edge E0+2 with result_o = 0.
- Signed 0x80000000 / 0xFFFFFFFF → {32'h00000000, 32'h80000000}. Same operands unsigned → {32'h80000000, 32'h00000000}.
- annul_i pulsed 10 cycles into ON → FREE next edge, ready_o never rises. A new 9 / 3 unsigned start then completes normally with {0, 3}.
- rst asserted low mid-ON (asynchronous to clk) → ready_o = 0 and result_o = 0 immediately. After release, FREE; a fresh start completes in 34 cycles.
